onewire_slave: RTL and testbench

Responder end of the team's single-wire (1-Wire style) bus: detects the master's reset pulse, answers with a presence pulse, decodes the 8-bit ROM command, serves Read ROM / Skip ROM / Match ROM, then receives one 64-bit data word. It sits on the same open-drain bus as the master, drives the line only through `slave_pull_low`, and presents received data to local logic.

---
 rtl/onewire_slave.sv | 189 ++++++++++++++++++
 tb/tb_onewire_slave.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/onewire_slave.sv
// Single-wire bus responder: reset/presence handling, ROM command stage (Read/Skip/Match ROM)
// and reception of one 64-bit data word, LSB first.
module onewire_slave #(
    parameter logic [63:0] ROM_ID    = 64'h2800_000A_BCDE_F001,
    parameter int unsigned RESET_MIN = 480,
    parameter int unsigned PRES_WAIT = 30,
    parameter int unsigned PRES_LEN  = 120,
    parameter int unsigned SAMPLE_AT = 15,
    parameter int unsigned DRIVE_LEN = 45
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_in,
    input  logic        en_slave,
    output logic        slave_pull_low,
    output logic [63:0] data_out,
    output logic        data_valid,
    output logic        selected
);

    localparam int unsigned LW = $clog2(RESET_MIN + 1);

    typedef enum logic [2:0] {
        StIdle, StWaitReset, StPresWait, StPresence, StRomCmd, StSendRom, StMatchRom, StRecvData
    } state_t;

    state_t         state;
    logic           sync1, bs, bs_prev;
    logic [LW-1:0]  low_cnt;
    logic           rst_seen;
    logic [15:0]    tmr;
    logic           slot_act;
    logic [6:0]     bit_cnt;
    logic [63:0]    sr;
    logic [63:0]    new_word;
    logic           fall, rise, rx_last;

    assign fall     = bs_prev & ~bs;
    assign rise     = ~bs_prev & bs;
    assign new_word = {bs, sr[63:1]};
    assign rx_last  = (state == StRomCmd) ? (bit_cnt == 7'd7) : (bit_cnt == 7'd63);

    // Synchronizer resets to the idle (released) bus level so no edge is seen out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b1;
            bs      <= 1'b1;
            bs_prev <= 1'b1;
        end else begin
            sync1   <= bus_in;
            bs      <= sync1;
            bs_prev <= bs;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= StIdle;
            slave_pull_low <= 1'b0;
            data_out       <= '0;
            data_valid     <= 1'b0;
            selected       <= 1'b0;
            low_cnt        <= '0;
            rst_seen       <= 1'b0;
            tmr            <= '0;
            slot_act       <= 1'b0;
            bit_cnt        <= '0;
            sr             <= '0;
        end else begin
            data_valid <= 1'b0;
            if (!en_slave) begin
                state          <= StIdle;
                slave_pull_low <= 1'b0;
                selected       <= 1'b0;
                low_cnt        <= '0;
                rst_seen       <= 1'b0;
                tmr            <= '0;
                slot_act       <= 1'b0;
                bit_cnt        <= '0;
                sr             <= '0;
            end else if (state == StIdle) begin
                state <= StWaitReset;
            end else begin
                if (bs) begin
                    low_cnt <= '0;
                end else if (low_cnt != LW'(RESET_MIN)) begin
                    low_cnt <= low_cnt + LW'(1);
                end
                if (!bs && low_cnt == LW'(RESET_MIN - 1)) rst_seen <= 1'b1;

                if (rise && rst_seen) begin
                    state          <= StPresWait;
                    rst_seen       <= 1'b0;
                    sr             <= '0;
                    bit_cnt        <= '0;
                    selected       <= 1'b0;
                    tmr            <= '0;
                    slot_act       <= 1'b0;
                    slave_pull_low <= 1'b0;
                end else begin
                    case (state)
                        StPresWait: begin
                            if (tmr == 16'(PRES_WAIT - 1)) begin
                                state          <= StPresence;
                                slave_pull_low <= 1'b1;
                                tmr            <= '0;
                            end else begin
                                tmr <= tmr + 16'd1;
                            end
                        end
                        StPresence: begin
                            if (tmr == 16'(PRES_LEN - 1)) begin
                                state          <= StRomCmd;
                                slave_pull_low <= 1'b0;
                                tmr            <= '0;
                                slot_act       <= 1'b0;
                            end else begin
                                tmr <= tmr + 16'd1;
                            end
                        end
                        StRomCmd, StMatchRom, StRecvData: begin
                            if (!slot_act) begin
                                if (fall) begin
                                    slot_act <= 1'b1;
                                    tmr      <= '0;
                                end
                            end else if (tmr == 16'(SAMPLE_AT)) begin
                                slot_act <= 1'b0;
                                sr       <= new_word;
                                bit_cnt  <= bit_cnt + 7'd1;
                                if (rx_last) begin
                                    sr      <= '0;
                                    bit_cnt <= '0;
                                    if (state == StRomCmd) begin
                                        case (new_word[63:56])
                                            8'h33:   state <= StSendRom;
                                            8'hCC: begin
                                                state    <= StRecvData;
                                                selected <= 1'b1;
                                            end
                                            8'h55:   state <= StMatchRom;
                                            default: state <= StWaitReset;
                                        endcase
                                    end else if (state == StMatchRom) begin
                                        if (new_word == ROM_ID) begin
                                            state    <= StRecvData;
                                            selected <= 1'b1;
                                        end else begin
                                            state <= StWaitReset;
                                        end
                                    end else begin
                                        data_out   <= new_word;
                                        data_valid <= 1'b1;
                                        state      <= StWaitReset;
                                    end
                                end
                            end else begin
                                tmr <= tmr + 16'd1;
                            end
                        end
                        StSendRom: begin
                            if (!slot_act) begin
                                if (fall) begin
                                    slot_act       <= 1'b1;
                                    tmr            <= '0;
                                    slave_pull_low <= ~ROM_ID[bit_cnt[5:0]];
                                end
                            end else if (tmr == 16'(DRIVE_LEN - 1)) begin
                                slot_act       <= 1'b0;
                                slave_pull_low <= 1'b0;
                                if (bit_cnt == 7'd63) begin
                                    bit_cnt  <= '0;
                                    state    <= StRecvData;
                                    selected <= 1'b1;
                                end else begin
                                    bit_cnt <= bit_cnt + 7'd1;
                                end
                            end else begin
                                tmr <= tmr + 16'd1;
                            end
                        end
                        default: ; // StWaitReset: slots are ignored until a reset pulse
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_onewire_slave.sv
// Directed bench for onewire_slave: an open-drain bus model with a bit-banged master.
module tb_onewire_slave;

    localparam logic [63:0] ROM = 64'h2800_000A_BCDE_F001;
    localparam logic [63:0] D1  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D2  = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] D3  = 64'h5A5A_0F0F_1234_8001;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_slave;
    logic        m_low;
    logic        bus_in;
    logic        slave_pull_low;
    logic [63:0] data_out;
    logic        data_valid;
    logic        selected;

    int n_checks = 0;
    int n_pass   = 0;
    int dv_cnt   = 0;

    assign bus_in = ~(m_low | slave_pull_low);

    onewire_slave dut (
        .clk            (clk),
        .reset          (reset),
        .bus_in         (bus_in),
        .en_slave       (en_slave),
        .slave_pull_low (slave_pull_low),
        .data_out       (data_out),
        .data_valid     (data_valid),
        .selected       (selected)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (data_valid) dv_cnt <= dv_cnt + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Master reset pulse followed by a measured presence pulse.
    task automatic do_reset(input int len);
        int i;
        int n;
        m_low = 1'b1;
        repeat (len) tick;
        m_low = 1'b0;
        i = 0;
        while (!slave_pull_low && i < 300) begin
            tick;
            i++;
        end
        check("pres_delay", i, 33);
        n = 0;
        while (slave_pull_low && n < 300) begin
            tick;
            n++;
        end
        check("pres_len", n, 120);
        repeat (5) tick;
    endtask

    task automatic write_bit(input logic b);
        m_low = 1'b1;
        repeat (b ? 5 : 60) tick;
        m_low = 1'b0;
        repeat (b ? 65 : 10) tick;
    endtask

    task automatic write_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) write_bit(v[i]);
    endtask

    task automatic write_word(input logic [63:0] v);
        for (int i = 0; i < 64; i++) write_bit(v[i]);
    endtask

    task automatic read_slot(output int driven);
        driven = 0;
        m_low = 1'b1;
        for (int k = 0; k < 70; k++) begin
            tick;
            if (k == 1) m_low = 1'b0;
            if (slave_pull_low) driven++;
        end
    endtask

    initial begin
        int          i;
        int          drv;
        logic [63:0] rom_v;
        rom_v    = ROM;
        reset    = 1'b1;
        en_slave = 1'b0;
        m_low    = 1'b0;
        repeat (5) tick;
        check("rst_pull", slave_pull_low, 0);
        check("rst_data", data_out, 0);
        check("rst_dv", data_valid, 0);
        check("rst_sel", selected, 0);
        reset    = 1'b0;
        en_slave = 1'b1;
        repeat (10) tick;

        // Too-short low pulse: no presence
        m_low = 1'b1;
        repeat (400) tick;
        m_low = 1'b0;
        i = 0;
        while (!slave_pull_low && i < 300) begin
            tick;
            i++;
        end
        check("short_no_pres", i, 300);
        check("short_sel", selected, 0);

        // Skip ROM then data
        do_reset(500);
        write_byte(8'hCC);
        check("skip_sel", selected, 1);
        write_word(D1);
        check("skip_dv_cnt", dv_cnt, 1);
        check("skip_data", data_out, D1);
        check("skip_sel_hold", selected, 1);

        // Read ROM: slave drives exactly in slots whose ROM bit is 0
        do_reset(500);
        check("rd_sel_clr", selected, 0);
        write_byte(8'h33);
        for (int b = 0; b < 64; b++) begin
            read_slot(drv);
            check($sformatf("rom_bit%0d", b), drv, rom_v[b] ? 0 : 45);
        end
        check("rd_sel", selected, 1);
        write_word(D2);
        check("rd_dv_cnt", dv_cnt, 2);
        check("rd_data", data_out, D2);

        // Match ROM with a wrong code
        do_reset(500);
        write_byte(8'h55);
        write_word(rom_v ^ 64'd1);
        check("mm_sel", selected, 0);
        write_word(D3);
        check("mm_dv_cnt", dv_cnt, 2);
        check("mm_data", data_out, D2);

        // Match ROM with the correct code
        do_reset(500);
        write_byte(8'h55);
        write_word(rom_v);
        check("m_sel", selected, 1);
        write_word(D3);
        check("m_dv_cnt", dv_cnt, 3);
        check("m_data", data_out, D3);

        // Reset pulse after 20 data bits discards the partial word
        do_reset(500);
        write_byte(8'hCC);
        for (int b = 0; b < 20; b++) write_bit(D1[b]);
        check("abort_sel_pre", selected, 1);
        do_reset(500);
        check("abort_sel", selected, 0);
        check("abort_dv_cnt", dv_cnt, 3);
        check("abort_data", data_out, D3);

        // Disable mid read slot while the slave is driving
        write_byte(8'h33);
        read_slot(drv);
        check("en_bit0", drv, 0);
        m_low = 1'b1;
        tick;
        tick;
        m_low = 1'b0;
        repeat (5) tick;
        check("en_drive", slave_pull_low, 1);
        en_slave = 1'b0;
        tick;
        check("en_release", slave_pull_low, 0);
        check("en_sel", selected, 0);
        check("en_data_keep", data_out, D3);
        repeat (5) tick;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
